// File: rtl/mcycle_engine_pkg.sv
// Shared processor definitions for the multi-cycle multiply/divide engine:
// FSM state encoding and the MCycleOp operation encoding.
package mcycle_engine_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mcState_t;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } mcOp_t;

endpackage

// File: rtl/mcycle_engine_if.sv
// Request/result bundle between the control unit (master) and the
// multi-cycle engine (slave).
interface mcycle_engine_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_engine.sv
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) engine.
// One bit is processed per clock over a shared 2*WIDTH accumulator:
//   multiply: acc = {product high, multiplier/product low}
//   divide:   acc = {remainder, dividend/quotient}
module mcycle_engine
  import mcycle_engine_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  mcycle_engine_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mcState_t           state;
  mcState_t           stateNext;
  logic               startAccept;
  logic               lastIter;
  logic [CNT_W-1:0]   iterCnt;
  mcOp_t              opReg;
  logic [WIDTH-1:0]   opB;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH-1:0] divNext;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH+1:0]   divDiff;
  logic               divBorrow;
  logic [WIDTH-1:0]   result1Reg;
  logic [WIDTH-1:0]   result2Reg;

  assign lastIter    = (iterCnt == CNT_W'(WIDTH - 1));
  assign bus.Busy    = (state == COMPUTE);
  assign bus.Done    = (state == DONE);
  assign bus.Result1 = result1Reg;
  assign bus.Result2 = result2Reg;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic; a Start is only honoured when no operation is iterating.
  always_comb begin
    stateNext   = state;
    startAccept = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          startAccept = 1'b1;
          stateNext   = COMPUTE;
        end
      end
      COMPUTE: begin
        if (lastIter) stateNext = DONE;
      end
      DONE: begin
        if (bus.Start) begin
          startAccept = 1'b1;
          stateNext   = COMPUTE;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // One iteration step for each operation; a zero divisor never borrows,
  // which naturally yields an all-ones quotient and the dividend as remainder.
  // A real difference never reaches bit WIDTH, so bit WIDTH is only set by
  // the sign extension of a borrow.
  always_comb begin
    mulSum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : {(WIDTH+1){1'b0}});
    mulNext   = {mulSum, acc[WIDTH-1:1]};
    divShift  = acc[2*WIDTH-1:WIDTH-1];
    divDiff   = {1'b0, divShift} - {2'b00, opB};
    divBorrow = divDiff[WIDTH+1] | divDiff[WIDTH];
    divNext   = divBorrow ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                          : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    accNext   = (opReg == DIV) ? divNext : mulNext;
  end

  // Operand capture, iteration and result registers; results only update on
  // the final iteration so they stay stable through DONE and afterwards.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      acc        <= '0;
      opB        <= '0;
      opReg      <= MUL;
      iterCnt    <= '0;
      result1Reg <= '0;
      result2Reg <= '0;
    end else if (startAccept) begin
      opReg   <= mcOp_t'(bus.MCycleOp);
      iterCnt <= '0;
      if (bus.MCycleOp == DIV) begin
        acc <= {{WIDTH{1'b0}}, bus.Operand1};
        opB <= bus.Operand2;
      end else begin
        acc <= {{WIDTH{1'b0}}, bus.Operand2};
        opB <= bus.Operand1;
      end
    end else if (state == COMPUTE) begin
      acc     <= accNext;
      iterCnt <= iterCnt + CNT_W'(1);
      if (lastIter) begin
        result1Reg <= accNext[WIDTH-1:0];
        result2Reg <= accNext[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mcycle_engine.sv
// Self-checking bench for mcycle_engine: table of multiply/divide vectors
// with hand-computed results, plus sequences for mid-operation Start,
// back-to-back requests and reset during an operation.
module tb_mcycle_engine;
  import mcycle_engine_pkg::*;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;
  localparam int NUM_VEC = 12;

  typedef struct {
    mcOp_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp1;
    logic [31:0] exp2;
    string       name;
  } vecRec_t;

  logic    clk;
  logic    reset;
  int      checkCount;
  int      failCount;
  vecRec_t vecs[NUM_VEC];

  mcycle_engine_if #(.WIDTH(WIDTH)) bus ();

  mcycle_engine #(.WIDTH(WIDTH)) dut (
    .CLK   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Present a request for one cycle starting at the current falling edge.
  task automatic applyStimulus(input mcOp_t op, input logic [31:0] a, input logic [31:0] b);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
  endtask

  // Let the request be sampled, scramble the operands, optionally re-pulse
  // Start mid-operation, then wait for Done and check latency and results.
  task automatic checkOutput(input string name, input logic [31:0] exp1, input logic [31:0] exp2,
                             input int pulseAt);
    int cycles;
    @(posedge clk);
    @(negedge clk);
    cycles       = 1;
    bus.Start    = 1'b0;
    bus.Operand1 = $urandom;
    bus.Operand2 = $urandom;
    bus.MCycleOp = ~bus.MCycleOp;
    checkVal({name, " busy"}, {63'd0, bus.Busy}, 64'd1);
    while (!bus.Done && cycles < 100) begin
      if (cycles == pulseAt) begin
        bus.Start    = 1'b1;
        bus.MCycleOp = ~bus.MCycleOp;
        bus.Operand1 = 32'd100;
        bus.Operand2 = 32'd7;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    bus.Start = 1'b0;
    checkVal({name, " latency"}, 64'(cycles), 64'(LATENCY));
    checkVal({name, " done"}, {63'd0, bus.Done}, 64'd1);
    checkVal({name, " result1"}, {32'd0, bus.Result1}, {32'd0, exp1});
    checkVal({name, " result2"}, {32'd0, bus.Result2}, {32'd0, exp2});
  endtask

  // The cycle after Done: pulse over, engine idle, results held.
  task automatic checkHold(input string name, input logic [31:0] exp1, input logic [31:0] exp2);
    @(posedge clk);
    @(negedge clk);
    checkVal({name, " done pulse"}, {63'd0, bus.Done}, 64'd0);
    checkVal({name, " idle busy"}, {63'd0, bus.Busy}, 64'd0);
    checkVal({name, " hold r1"}, {32'd0, bus.Result1}, {32'd0, exp1});
    checkVal({name, " hold r2"}, {32'd0, bus.Result2}, {32'd0, exp2});
  endtask

  // Main test sequence.
  initial begin
    int doneSeen;
    checkCount   = 0;
    failCount    = 0;
    reset        = 1'b0;
    bus.Start    = 1'b0;
    bus.MCycleOp = 1'b0;
    bus.Operand1 = '0;
    bus.Operand2 = '0;

    vecs[0]  = '{MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0000_0000, "mul 7x6"};
    vecs[1]  = '{MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, "mul max x max"};
    vecs[2]  = '{MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, "mul x16"};
    vecs[3]  = '{MUL, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, "mul zero"};
    vecs[4]  = '{MUL, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001, "mul carry out"};
    vecs[5]  = '{DIV, 32'd100,       32'd7,         32'd14,        32'd2,         "div 100/7"};
    vecs[6]  = '{DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         "div by zero"};
    vecs[7]  = '{DIV, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         "div by one"};
    vecs[8]  = '{DIV, 32'd3,         32'd10,        32'd0,         32'd3,         "div small"};
    vecs[9]  = '{DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         "div max/max"};
    vecs[10] = '{DIV, 32'd1000,      32'd10,        32'd100,       32'd0,         "div 1000/10"};
    vecs[11] = '{DIV, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'd2,         "div msb/3"};

    // Reset state while held in reset.
    #3;
    checkVal("reset busy", {63'd0, bus.Busy}, 64'd0);
    checkVal("reset done", {63'd0, bus.Done}, 64'd0);
    checkVal("reset r1", {32'd0, bus.Result1}, 64'd0);
    checkVal("reset r2", {32'd0, bus.Result2}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table vectors, each followed by an idle cycle.
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].exp1, vecs[i].exp2, 0);
      checkHold(vecs[i].name, vecs[i].exp1, vecs[i].exp2);
    end

    // Start re-pulsed mid-operation with other operands must be ignored.
    applyStimulus(MUL, 32'd7, 32'd6);
    checkOutput("repulse", 32'h2A, 32'h0, 5);
    checkHold("repulse", 32'h2A, 32'h0);

    // Back-to-back: second request issued in the DONE cycle.
    applyStimulus(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("b2b first", 32'h1, 32'hFFFF_FFFE, 0);
    applyStimulus(DIV, 32'd100, 32'd7);
    checkOutput("b2b second", 32'd14, 32'd2, 0);
    checkHold("b2b second", 32'd14, 32'd2);

    // Reset asserted in the middle of an operation.
    applyStimulus(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkVal("pre-reset busy", {63'd0, bus.Busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    checkVal("async reset busy", {63'd0, bus.Busy}, 64'd0);
    checkVal("async reset done", {63'd0, bus.Done}, 64'd0);
    checkVal("async reset r1", {32'd0, bus.Result1}, 64'd0);
    checkVal("async reset r2", {32'd0, bus.Result2}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) doneSeen++;
    end
    checkVal("no done after abort", 64'(doneSeen), 64'd0);
    checkVal("idle after abort", {63'd0, bus.Busy}, 64'd0);

    // Normal operation after the aborted one.
    applyStimulus(DIV, 32'd100, 32'd7);
    checkOutput("post-reset", 32'd14, 32'd2, 0);
    checkHold("post-reset", 32'd14, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mcycle_engine.md
MCYCLE_ENGINE -- requirements
Module: mcycle_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Start  input  1  request pulse from the control unit (M_Start).
REQ-005 SHALL have port MCycleOp  input  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-006 SHALL have port Operand1  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port Operand2  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port Result1  output  WIDTH  product low half or quotient.
REQ-009 SHALL have port Result2  output  WIDTH  product high half or remainder.
REQ-010 SHALL have port Busy  output  1  high while an operation is iterating.
REQ-011 SHALL have port Done  output  1  one-cycle completion pulse (done).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, COMPUTE, DONE.
REQ-013 IDLE, Start=1: on that edge SHALL latch Operand1, Operand2 and MCycleOp, clear the iteration counter, and enter COMPUTE.
REQ-014 COMPUTE SHALL perform exactly one bit-iteration per cycle for WIDTH cycles, then enter DONE.
REQ-015 Multiply SHALL be shift-add over a 2*WIDTH accumulator: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift right one bit.
REQ-016 Divide SHALL be restoring: shift the next dividend MSB into the remainder, trial-subtract the divisor, keep the difference and set the quotient bit to 1 if there is no borrow, otherwise set the quotient bit to 0.
REQ-017 Done SHALL be 1 only in the DONE state, for exactly one cycle; with Start high in cycle N, Done is high in cycle N+WIDTH+1.
REQ-018 Busy SHALL be 1 in COMPUTE only, and 0 in IDLE and DONE.
REQ-019 Result1/Result2 SHALL be registered, valid when Done=1, and held stable until the next accepted Start.
REQ-020 Start while in COMPUTE SHALL be ignored, with no effect on the operation in progress.
REQ-021 Start=1 in the DONE cycle SHALL be accepted as a back-to-back request, handled as in IDLE.
REQ-022 Divide by zero SHALL complete with normal latency: Result1 = all ones, Result2 = Operand1.
REQ-023 Operand input changes after the Start edge SHALL NOT affect the operation in progress.
REQ-024 All arithmetic SHALL be unsigned; the product is full 2*WIDTH with no overflow.

Reset
REQ-025 Reset=0 SHALL immediately force IDLE, counter=0, Busy=0, Done=0, Result1=0, Result2=0, independent of CLK.
REQ-026 Reset asserted mid-COMPUTE SHALL abort the operation, produce no Done pulse, and leave the block ready for Start on the first edge after release.

Structure
REQ-027 The FSM state encoding and the MCycleOp encodings (MUL=0, DIV=1) SHALL live in the shared processor package.
REQ-028 The datapath SHALL be a single module with no sub-module; the iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-029 MUL 0x0000_0007 x 0x0000_0006, Start in cycle 0 -> Done in cycle 33 with Result1=0x2A, Result2=0.
REQ-030 MUL 0xFFFF_FFFF x 0xFFFF_FFFF -> Result2=0xFFFF_FFFE, Result1=0x0000_0001.
REQ-031 DIV 100 / 7 -> Result1=14, Result2=2; DIV 5 / 0 -> Result1=0xFFFF_FFFF, Result2=5, same latency.
REQ-032 Start re-pulsed mid-COMPUTE with different operands -> original result returned, Done still in cycle 33; Start in the DONE cycle -> second Done exactly 33 cycles later.
REQ-033 Reset pulsed low in cycle 10 of COMPUTE -> Busy/Done/results 0 asynchronously, no Done pulse, next Start completes normally.
